alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that drives the CPU's shared 8-bit combinational ALU to perform unsigned 8x8->16 multiply and unsigned 8/8 divide (quotient and remainder).
- Issues exactly one ALU operation per clock, using the existing ALU mode encodings.
- Sits beside the CPU control unit, which muxes the ALU inputs to this block while busy is high.

---
 rtl/alu_muldiv_seq_if.sv | 42 ++++
 rtl/alu_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq_if
//   Bundles the signals between the CPU control unit, the shared 8-bit ALU and
//   the multiply/divide sequencer.
//
//   Command side : start, op (0 = MUL, 1 = DIV), opa, opb
//   Result side  : busy, done, dz, res_hi, res_lo
//   ALU side     : alu_a, alu_b, alu_mode, alu_cin  (sequencer -> ALU)
//                  alu_out, alu_cout                (ALU -> sequencer, same cycle)
//
//   slave  : the sequencer itself
//   master : the surroundings (control unit plus ALU)
// ---------------------------------------------------------------------------
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_mode;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;

    modport slave (
        input  start, op, opa, opb, alu_out, alu_cout,
        output busy, done, dz, res_hi, res_lo, alu_a, alu_b, alu_mode, alu_cin
    );

    modport master (
        output start, op, opa, opb, alu_out, alu_cout,
        input  busy, done, dz, res_hi, res_lo, alu_a, alu_b, alu_mode, alu_cin
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle sequencer that borrows the CPU's combinational 8-bit ALU to
//   perform an unsigned 8x8->16 multiply (shift-add) or an unsigned 8/8
//   restoring divide. One ALU operation is issued per clock; each of the
//   eight iterations takes three states (S_A, S_B, S_C), followed by FIN.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : alu_muldiv_seq_if.slave (command, result and ALU signals)
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_muldiv_seq_if.slave    bus
);

    localparam logic [3:0] MODE_PASS = 4'b0000;
    localparam logic [3:0] MODE_ADD  = 4'b0101;
    localparam logic [3:0] MODE_SUB  = 4'b1000;
    localparam logic [3:0] MODE_RLC  = 4'b1101;
    localparam logic [3:0] MODE_RRC  = 4'b1110;

    typedef enum logic [2:0] {IDLE, S_A, S_B, S_C, FIN} state_t;

    state_t           r_state, w_stateNext;
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic [WIDTH-1:0] w_hiNext, w_loNext, w_mNext;
    logic             r_c, w_cNext;
    logic [2:0]       r_cnt, w_cntNext;
    logic             r_opr, w_oprNext;
    logic             r_dz, w_dzNext;
    logic [WIDTH-1:0] r_resHi, r_resLo;
    logic [3:0]       w_aluMode;
    logic [WIDTH-1:0] w_aluA, w_aluB;
    logic             w_aluCin;

    // Next-state and ALU control. The ALU is driven purely from the current
    // state, and its same-cycle result is folded into the next register values.
    always_comb begin
        w_stateNext = r_state;
        w_hiNext    = r_hi;
        w_loNext    = r_lo;
        w_mNext     = r_m;
        w_cNext     = r_c;
        w_cntNext   = r_cnt;
        w_oprNext   = r_opr;
        w_dzNext    = r_dz;
        w_aluMode   = MODE_PASS;
        w_aluA      = '0;
        w_aluB      = '0;
        w_aluCin    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_oprNext = bus.op;
                    w_hiNext  = '0;
                    w_cntNext = '0;
                    w_dzNext  = 1'b0;
                    if (bus.op) begin
                        w_mNext  = bus.opb;
                        w_loNext = bus.opa;
                        // Divide by zero short-circuits straight to FIN.
                        if (bus.opb == '0) begin
                            w_hiNext    = bus.opa;
                            w_loNext    = '1;
                            w_dzNext    = 1'b1;
                            w_stateNext = FIN;
                        end else begin
                            w_stateNext = S_A;
                        end
                    end else begin
                        w_mNext     = bus.opa;
                        w_loNext    = bus.opb;
                        w_stateNext = S_A;
                    end
                end
            end

            S_A: begin
                if (!r_opr) begin
                    // Add multiplicand when the current multiplier bit is set.
                    w_aluA    = r_hi;
                    if (r_lo[0]) begin
                        w_aluMode = MODE_ADD;
                        w_aluB    = r_m;
                    end
                    w_hiNext = bus.alu_out;
                    w_cNext  = bus.alu_cout;
                end else begin
                    // Shift the dividend MSB out into the carry.
                    w_aluMode = MODE_RLC;
                    w_aluA    = r_lo;
                    w_loNext  = bus.alu_out;
                    w_cNext   = bus.alu_cout;
                end
                w_stateNext = S_B;
            end

            S_B: begin
                w_aluA   = r_hi;
                w_aluCin = r_c;
                w_aluMode = r_opr ? MODE_RLC : MODE_RRC;
                w_hiNext = bus.alu_out;
                w_cNext  = bus.alu_cout;
                w_stateNext = S_C;
            end

            S_C: begin
                if (!r_opr) begin
                    w_aluMode = MODE_RRC;
                    w_aluA    = r_lo;
                    w_aluCin  = r_c;
                    w_loNext  = bus.alu_out;
                end else begin
                    // Partial remainder is 9 bits {c, hi}; subtract only if it
                    // fits, otherwise restore by leaving hi untouched.
                    w_aluMode = MODE_SUB;
                    w_aluA    = r_hi;
                    w_aluB    = r_m;
                    if (r_c || !bus.alu_cout) begin
                        w_hiNext    = bus.alu_out;
                        w_loNext[0] = 1'b1;
                    end
                end
                if (r_cnt == 3'd7) begin
                    w_stateNext = FIN;
                end else begin
                    w_cntNext   = r_cnt + 3'd1;
                    w_stateNext = S_A;
                end
            end

            FIN: begin
                w_stateNext = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State and datapath registers. The result registers load on entry to
    // FIN so that res_hi/res_lo are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_opr   <= 1'b0;
            r_dz    <= 1'b0;
            r_resHi <= '0;
            r_resLo <= '0;
        end else begin
            r_state <= w_stateNext;
            r_hi    <= w_hiNext;
            r_lo    <= w_loNext;
            r_m     <= w_mNext;
            r_c     <= w_cNext;
            r_cnt   <= w_cntNext;
            r_opr   <= w_oprNext;
            r_dz    <= w_dzNext;
            if (w_stateNext == FIN) begin
                r_resHi <= w_hiNext;
                r_resLo <= w_loNext;
            end
        end
    end

    assign bus.busy     = (r_state == S_A) || (r_state == S_B) || (r_state == S_C);
    assign bus.done     = (r_state == FIN);
    assign bus.dz       = r_dz;
    assign bus.res_hi   = r_resHi;
    assign bus.res_lo   = r_resLo;
    assign bus.alu_a    = w_aluA;
    assign bus.alu_b    = w_aluB;
    assign bus.alu_mode = w_aluMode;
    assign bus.alu_cin  = w_aluCin;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//   Scoreboard bench for alu_muldiv_seq. Stimulus pushes the expected result
//   (from plain * / % arithmetic) and due cycle into a queue; a monitor pops
//   and compares on every done pulse. The shared ALU is modelled here too.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dz;
        int         dueCycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   doneSeen = 0;
    int   pushes = 0;
    exp_t sbQ[$];
    exp_t lastExp;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural model of the CPU's combinational ALU.
    always_comb begin
        bus.alu_out  = bus.alu_a;
        bus.alu_cout = 1'b0;
        case (bus.alu_mode)
            4'b0101: {bus.alu_cout, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
            4'b1000: begin
                bus.alu_out  = bus.alu_a - bus.alu_b;
                bus.alu_cout = (bus.alu_a < bus.alu_b);
            end
            4'b1101: {bus.alu_cout, bus.alu_out} = {bus.alu_a, bus.alu_cin};
            4'b1110: {bus.alu_out, bus.alu_cout} = {bus.alu_cin, bus.alu_a};
            default: ;
        endcase
    end

    function automatic exp_t refModel(input logic op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [15:0] p;
        e.dueCycle = 0;
        e.dz = 1'b0;
        if (!op) begin
            p = 16'(a) * 16'(b);
            e.hi = p[15:8];
            e.lo = p[7:0];
        end else if (b == 8'd0) begin
            e.hi = a;
            e.lo = 8'hFF;
            e.dz = 1'b1;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            doneSeen++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("res_hi", int'(bus.res_hi), int'(e.hi));
                checkOutput("res_lo", int'(bus.res_lo), int'(e.lo));
                checkOutput("dz", int'(bus.dz), int'(e.dz));
                checkOutput("done_cycle", cyc, e.dueCycle);
                lastExp = e;
            end
        end
    end

    task automatic checkAllZero(input string name);
        checkOutput(name, int'({bus.busy, bus.done, bus.dz, bus.res_hi, bus.res_lo,
                                bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_cin}), 0);
    endtask

    // Issues one start pulse; optionally records the expected response.
    task automatic applyStimulus(input logic op, input logic [7:0] a, input logic [7:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        if (push) begin
            e = refModel(op, a, b);
            e.dueCycle = cyc + ((op && b == 8'd0) ? 1 : 25);
            sbQ.push_back(e);
            pushes++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.opa   = 8'($urandom);
        bus.opb   = 8'($urandom);
        if (push) checkOutput("busy_after_start", int'(bus.busy), (op && b == 8'd0) ? 0 : 1);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40 && sbQ.size() != 0; i++) @(negedge clk);
        if (sbQ.size() != 0) begin
            checkOutput("done_timeout", 1, 0);
            sbQ.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("res_hold", int'({bus.dz, bus.res_hi, bus.res_lo}),
                    int'({lastExp.dz, lastExp.hi, lastExp.lo}));
        checkOutput("alu_idle", int'({bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_cin, bus.busy}), 0);
    endtask

    task automatic runOp(input logic op, input logic [7:0] a, input logic [7:0] b);
        applyStimulus(op, a, b, 1'b1);
        waitDone();
    endtask

    initial begin
        int savedDone;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.opa   = 8'd0;
        bus.opb   = 8'd0;
        lastExp   = '{hi: 8'd0, lo: 8'd0, dz: 1'b0, dueCycle: 0};

        repeat (3) @(negedge clk);
        checkAllZero("reset_state");
        rst_n = 1'b1;

        runOp(1'b0, 8'h0D, 8'h0B);
        runOp(1'b0, 8'hFF, 8'hFF);
        runOp(1'b0, 8'h00, 8'h5A);
        runOp(1'b1, 8'd200, 8'd7);
        runOp(1'b1, 8'hFF, 8'h01);
        runOp(1'b1, 8'd5, 8'd9);
        runOp(1'b1, 8'd100, 8'd0);
        runOp(1'b0, 8'h80, 8'h01);

        // A second start mid-multiply must be ignored.
        savedDone = doneSeen;
        applyStimulus(1'b0, 8'h37, 8'h5C, 1'b1);
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.opa   = 8'hAA;
        bus.opb   = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone();
        repeat (5) @(negedge clk);
        checkOutput("ignored_start_done_count", doneSeen - savedDone, 1);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            if (i % 7 == 3) rb = 8'd0;
            runOp(1'($urandom), 8'($urandom), rb);
        end

        // Reset in the middle of a divide aborts it without a done pulse.
        runOp(1'b1, 8'd200, 8'd7);
        savedDone = doneSeen;
        applyStimulus(1'b1, 8'd250, 8'd3, 1'b0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkAllZero("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("no_done_after_abort", doneSeen - savedDone, 0);
        runOp(1'b1, 8'd250, 8'd3);

        checkOutput("total_done_pulses", doneSeen, pushes);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
